// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline register fields in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_write_reg;
    logic        mem_mem_read;
    logic        mem_reg_write;
    logic [4:0]  mem_write_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic        mem_pc_select;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_write_reg,
               mem_mem_read, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, mem_pc_select,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, state,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_write_reg,
               mem_mem_read, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, mem_pc_select,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, state,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage stall/flush/forward control with event counters.
// Define HAZARD_FORWARD_EN to add EX operand forwarding (load-use is then the only stall).
module pipeline_hazard_ctrl (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_ex_hit;
    logic        w_mem_hit;
    logic        w_wb_hit;
    logic        w_hazard;
    logic        w_redirect;
    logic        w_stall;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    function automatic logic f_match(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 5'd0 && dst == src;
    endfunction

    function automatic logic f_id_hit(input logic we, input logic [4:0] dst);
        return f_match(we, dst, bus.id_rs) || (bus.id_uses_rt && f_match(we, dst, bus.id_rt));
    endfunction

    assign w_ex_hit  = f_id_hit(bus.ex_reg_write, bus.ex_write_reg);
    assign w_mem_hit = f_id_hit(bus.mem_reg_write, bus.mem_write_reg);
    assign w_wb_hit  = f_id_hit(bus.wb_reg_write, bus.wb_write_reg);

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] f_fwd(input logic [4:0] src);
        return (f_match(bus.mem_reg_write, bus.mem_write_reg, src) && !bus.mem_mem_read) ? 2'b10 :
               f_match(bus.wb_reg_write, bus.wb_write_reg, src) ? 2'b01 : 2'b00;
    endfunction

    assign w_hazard = bus.ex_mem_read && w_ex_hit;
    assign w_fwd_a  = f_fwd(bus.ex_rs);
    assign w_fwd_b  = f_fwd(bus.ex_rt);
`else
    logic w_unused;
    assign w_unused = ^{bus.ex_rs, bus.ex_rt, bus.ex_mem_read, bus.mem_mem_read};
    assign w_hazard = w_ex_hit || w_mem_hit || w_wb_hit;
    assign w_fwd_a  = 2'b00;
    assign w_fwd_b  = 2'b00;
`endif

    // A redirect seen in FLUSH is the same branch still sitting in MEM, so it is dropped.
    assign w_redirect = bus.mem_pc_select && r_state != FLUSH;
    assign w_stall    = w_hazard && !w_redirect;

    always_comb begin
        w_next = RUN;
        if (w_redirect)
            w_next = FLUSH;
        else if (w_hazard)
            w_next = STALL;
    end

    assign bus.pc_write    = !reset && !w_stall;
    assign bus.ifid_write  = !reset && !w_stall;
    assign bus.ifid_flush  = reset || w_redirect;
    assign bus.idex_flush  = reset || w_redirect || w_stall;
    assign bus.exmem_flush = reset || w_redirect;
    assign bus.fwd_a       = reset ? 2'b00 : w_fwd_a;
    assign bus.fwd_b       = reset ? 2'b00 : w_fwd_b;
    assign bus.state       = reset ? RUN : r_state;
    assign bus.stall_cnt   = reset ? 16'd0 : r_stall_cnt;
    assign bus.flush_cnt   = reset ? 16'd0 : r_flush_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_redirect && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end
endmodule
